// File: rtl/output_port_scheduler.sv
// Purpose: per-output-port wormhole scheduler. It grants one of 4 requesters in round-robin order
//          and holds that grant for a whole packet. A new grant needs enough downstream credits for a full packet.
// Latency: 1 cycle from request to grant. The grant drops 1 cycle after the last flit strobe of the packet.
// Backpressure: no new grant while credits < PACKET_FLITS. Credits are consumed by strobes taken while ACTIVE.
// Ports: clk, reset (sync, active-low); request_din[3:0] (level requests); transfer_strobe_din (one flit moved);
//        credit_din (downstream freed a slot); grant_vector_dout[3:0] (registered one-hot);
//        grant_valid_dout (registered OR of grant); credit_count_dout (current credits).
module output_port_scheduler #(
  parameter int PORT_DIR     = 0,   // direction of the served output port, debug only
  parameter int PACKET_FLITS = 5,
  parameter int BUFFER_DEPTH = 10,
  parameter int CREDIT_WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [3:0]              request_din,
  input  logic                    transfer_strobe_din,
  input  logic                    credit_din,
  output logic [3:0]              grant_vector_dout,
  output logic                    grant_valid_dout,
  output logic [CREDIT_WIDTH-1:0] credit_count_dout
);

  localparam int FW = (PACKET_FLITS > 1) ? $clog2(PACKET_FLITS) : 1;
  localparam logic [FW-1:0]           LAST_FLIT   = FW'(PACKET_FLITS - 1);
  localparam logic [CREDIT_WIDTH-1:0] PKT_CREDITS = CREDIT_WIDTH'(PACKET_FLITS);
  localparam logic [CREDIT_WIDTH-1:0] MAX_CREDITS = CREDIT_WIDTH'(BUFFER_DEPTH);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t                  state;
  logic [1:0]              rr_pointer;
  logic [1:0]              owner;
  logic [1:0]              winner;
  logic [1:0]              idx;
  logic                    found;
  logic [FW-1:0]           flit_count;
  logic [CREDIT_WIDTH-1:0] credits;
  logic                    can_start;
  logic                    strobe_taken;

  // The direction tag only labels the instance; fold it into a sink so it stays visible in netlists.
  logic unused_port_dir;
  assign unused_port_dir = ^PORT_DIR;

  // Round-robin pick: the first set request at or after rr_pointer, wrapping mod 4.
  always_comb begin
    winner = rr_pointer;
    found  = 1'b0;
    idx    = rr_pointer;
    for (int k = 0; k < 4; k++) begin
      idx = rr_pointer + 2'(k);
      if (!found && request_din[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  // Only start a packet when the whole packet already fits downstream.
  assign can_start    = (request_din != 4'b0000) && (credits >= PKT_CREDITS);
  assign strobe_taken = (state == ACTIVE) && transfer_strobe_din;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state             <= IDLE;
      rr_pointer        <= 2'd0;
      owner             <= 2'd0;
      flit_count        <= '0;
      grant_vector_dout <= 4'b0000;
      grant_valid_dout  <= 1'b0;
    end else if (state == IDLE) begin
      if (can_start) begin
        state             <= ACTIVE;
        owner             <= winner;
        flit_count        <= '0;
        grant_vector_dout <= 4'b0001 << winner;
        grant_valid_dout  <= 1'b1;
      end
    end else begin
      // Wormhole hold: request changes are ignored until the last flit has gone.
      if (transfer_strobe_din) begin
        if (flit_count == LAST_FLIT) begin
          state             <= IDLE;
          flit_count        <= '0;
          grant_vector_dout <= 4'b0000;
          grant_valid_dout  <= 1'b0;
          rr_pointer        <= owner + 2'd1;
        end else begin
          flit_count <= flit_count + 1'b1;
        end
      end
    end
  end

  // A strobe and a returned credit in the same cycle cancel each other out.
  // Saturate at both ends. An underflow could only come from a protocol error.
  always_ff @(posedge clk) begin
    if (!reset) begin
      credits <= MAX_CREDITS;
    end else if (strobe_taken && credit_din) begin
      credits <= credits;
    end else if (strobe_taken) begin
      if (credits != '0) credits <= credits - 1'b1;
    end else if (credit_din) begin
      if (credits != MAX_CREDITS) credits <= credits + 1'b1;
    end
  end

  assign credit_count_dout = credits;

endmodule

// File: tb/tb_output_port_scheduler.sv
// Bench for output_port_scheduler. Directed scenarios are followed by randomized traffic.
// Each one is compared cycle by cycle against an integer-level model of the scheduling rules.
module tb_output_port_scheduler;

  localparam int PF = 5;
  localparam int BD = 10;

  logic       clk;
  logic       reset;
  logic [3:0] request_din;
  logic       transfer_strobe_din;
  logic       credit_din;
  logic [3:0] grant_vector_dout;
  logic       grant_valid_dout;
  logic [3:0] credit_count_dout;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: owner = -1 means no grant is held.
  int m_owner = -1;
  int m_flits = 0;
  int m_cred  = BD;
  int m_rr    = 0;

  output_port_scheduler #(
    .PORT_DIR(0), .PACKET_FLITS(PF), .BUFFER_DEPTH(BD), .CREDIT_WIDTH(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .request_din(request_din),
    .transfer_strobe_din(transfer_strobe_din),
    .credit_din(credit_din),
    .grant_vector_dout(grant_vector_dout),
    .grant_valid_dout(grant_valid_dout),
    .credit_count_dout(credit_count_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] model_grant();
    logic [3:0] g;
    g = 4'b0000;
    if (m_owner >= 0) g[m_owner] = 1'b1;
    return g;
  endfunction

  task automatic model_update(input logic r, input logic [3:0] q, input logic s, input logic c);
    int  old_cred;
    bit  active;
    int  i;
    if (!r) begin
      m_owner = -1; m_flits = 0; m_cred = BD; m_rr = 0;
      return;
    end
    old_cred = m_cred;
    active   = (m_owner >= 0);
    if (active && s && c) m_cred = m_cred;
    else if (active && s) m_cred = (m_cred > 0) ? m_cred - 1 : 0;
    else if (c)           m_cred = (m_cred < BD) ? m_cred + 1 : BD;
    if (!active) begin
      if (q != 4'b0000 && old_cred >= PF) begin
        for (int k = 0; k < 4; k++) begin
          i = (m_rr + k) % 4;
          if (q[i] && m_owner < 0) m_owner = i;
        end
        m_flits = 0;
      end
    end else if (s) begin
      m_flits++;
      if (m_flits == PF) begin
        m_rr    = (m_owner + 1) % 4;
        m_owner = -1;
        m_flits = 0;
      end
    end
  endtask

  // One clock: drive on the falling edge, advance the model at the rising edge, check 1 time unit later.
  task automatic step(input logic r, input logic [3:0] q, input logic s, input logic c);
    @(negedge clk);
    reset = r; request_din = q; transfer_strobe_din = s; credit_din = c;
    @(posedge clk);
    model_update(r, q, s, c);
    #1;
    chk("grant_vector", 32'(grant_vector_dout), 32'(model_grant()));
    chk("grant_valid",  32'(grant_valid_dout),  32'(m_owner >= 0));
    chk("credit_count", 32'(credit_count_dout), 32'(m_cred));
  endtask

  task automatic do_reset();
    step(1'b0, 4'b0000, 1'b0, 1'b0);
    step(1'b0, 4'b0000, 1'b0, 1'b0);
  endtask

  logic [3:0] exp_order [5];

  initial begin
    reset = 1'b0; request_din = 4'b0000; transfer_strobe_din = 1'b0; credit_din = 1'b0;

    // Reset state.
    do_reset();
    chk("reset_grant", 32'(grant_vector_dout), 32'h0);
    chk("reset_valid", 32'(grant_valid_dout), 32'h0);
    chk("reset_credits", 32'(credit_count_dout), 32'd10);

    // Scenario 1: single request, full packet, credits drop by 5.
    step(1'b1, 4'b0100, 1'b0, 1'b0);
    chk("t1_grant", 32'(grant_vector_dout), 32'h4);
    chk("t1_credits", 32'(credit_count_dout), 32'd10);
    for (int k = 0; k < PF; k++) begin
      step(1'b1, 4'b0000, 1'b1, 1'b0);
      if (k == PF - 2) chk("t1_hold_before_last", 32'(grant_vector_dout), 32'h4);
    end
    chk("t1_release", 32'(grant_vector_dout), 32'h0);
    chk("t1_credits_after", 32'(credit_count_dout), 32'd5);

    // Scenario 2: all four request, credits refilled inside each packet; strict round-robin.
    do_reset();
    exp_order[0] = 4'b0001; exp_order[1] = 4'b0010; exp_order[2] = 4'b0100;
    exp_order[3] = 4'b1000; exp_order[4] = 4'b0001;
    step(1'b1, 4'b1111, 1'b0, 1'b0);
    for (int p = 0; p < 5; p++) begin
      chk("t2_order", 32'(grant_vector_dout), 32'(exp_order[p]));
      for (int k = 0; k < PF; k++) step(1'b1, 4'b1111, 1'b0, 1'b1);
      for (int k = 0; k < PF; k++) begin
        step(1'b1, 4'b1111, 1'b1, 1'b0);
        if (k == PF - 2) chk("t2_hold_4_strobes", 32'(grant_vector_dout), 32'(exp_order[p]));
      end
      chk("t2_release", 32'(grant_vector_dout), 32'h0);
      step(1'b1, 4'b1111, 1'b0, 1'b0);
    end

    // Scenario 3: credits at PACKET_FLITS-1 block a grant until one more credit arrives.
    do_reset();
    for (int p = 0; p < 2; p++) begin
      step(1'b1, 4'b0010, 1'b0, 1'b0);
      for (int k = 0; k < PF; k++) step(1'b1, 4'b0000, 1'b1, 1'b0);
    end
    chk("t3_credits_empty", 32'(credit_count_dout), 32'd0);
    for (int k = 0; k < 4; k++) step(1'b1, 4'b0000, 1'b0, 1'b1);
    step(1'b1, 4'b0001, 1'b0, 1'b0);
    step(1'b1, 4'b0001, 1'b0, 1'b0);
    chk("t3_no_grant_at_4", 32'(grant_vector_dout), 32'h0);
    chk("t3_credits_4", 32'(credit_count_dout), 32'd4);
    step(1'b1, 4'b0001, 1'b0, 1'b1);
    chk("t3_still_no_grant", 32'(grant_vector_dout), 32'h0);
    chk("t3_credits_5", 32'(credit_count_dout), 32'd5);
    step(1'b1, 4'b0001, 1'b0, 1'b0);
    chk("t3_grant_after_credit", 32'(grant_vector_dout), 32'h1);

    // Scenario 4: the granted request drops mid-packet while another port asks; the grant is held.
    do_reset();
    step(1'b1, 4'b0001, 1'b0, 1'b0);
    step(1'b1, 4'b0001, 1'b1, 1'b0);
    step(1'b1, 4'b0001, 1'b1, 1'b0);
    step(1'b1, 4'b0010, 1'b1, 1'b0);
    step(1'b1, 4'b0010, 1'b1, 1'b0);
    chk("t4_wormhole_hold", 32'(grant_vector_dout), 32'h1);
    step(1'b1, 4'b0010, 1'b1, 1'b0);
    chk("t4_release", 32'(grant_vector_dout), 32'h0);
    step(1'b1, 4'b0010, 1'b0, 1'b0);
    chk("t4_next_grant", 32'(grant_vector_dout), 32'h2);

    // Scenario 5: a strobe and a credit in the same cycle cancel; credit at full saturates.
    do_reset();
    step(1'b1, 4'b1000, 1'b0, 1'b0);
    step(1'b1, 4'b0000, 1'b1, 1'b1);
    chk("t5_both_unchanged", 32'(credit_count_dout), 32'd10);
    step(1'b1, 4'b0000, 1'b0, 1'b1);
    chk("t5_saturate", 32'(credit_count_dout), 32'd10);
    step(1'b1, 4'b0000, 1'b1, 1'b0);
    chk("t5_strobe_dec", 32'(credit_count_dout), 32'd9);
    step(1'b1, 4'b0000, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) step(1'b1, 4'b0000, 1'b1, 1'b0);
    step(1'b1, 4'b0000, 1'b1, 1'b0);   // strobe in IDLE is ignored
    chk("t5_idle_strobe_ignored", 32'(credit_count_dout), 32'd6);

    // Scenario 6: reset mid-packet abandons the grant and restores rr_pointer to 0.
    do_reset();
    step(1'b1, 4'b0010, 1'b0, 1'b0);
    for (int k = 0; k < PF; k++) step(1'b1, 4'b0000, 1'b1, 1'b0);
    step(1'b1, 4'b0100, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) step(1'b1, 4'b0000, 1'b1, 1'b0);
    step(1'b0, 4'b0000, 1'b0, 1'b0);
    chk("t6_reset_grant", 32'(grant_vector_dout), 32'h0);
    chk("t6_reset_credits", 32'(credit_count_dout), 32'd10);
    step(1'b1, 4'b1111, 1'b0, 1'b0);
    chk("t6_rr_restart", 32'(grant_vector_dout), 32'h1);

    // Randomized traffic against the model.
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      step(($urandom_range(0, 199) != 0),
           4'($urandom_range(0, 15)),
           ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 2) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
